// File: rtl/move_issuer.sv
// Issues one move for the current player: a burst of single-cycle step strobes on p_da[turn],
// then a done pulse and a turn hand-off. Define MOVE_ISSUER_GAP_EN to insert a idle cycle between strobes.
module move_issuer #(
    parameter int STEP_W = 3
) (
    input  logic              B,
    input  logic              rst,
    input  logic [3:0]        N,
    input  logic              start,
    input  logic [STEP_W-1:0] steps,
    output logic [3:0]        p_da,
    output logic [1:0]        turn,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        GAP,
        FIN
    } state_t;

    state_t            state, state_next;
    // Strobes still owed after the one currently on p_da.
    logic [STEP_W-1:0] remaining, remaining_next;
    logic [1:0]        turn_next;
    logic [3:0]        p_da_next;
    logic              busy_next;
    logic              done_next;
    logic              n_legal;
    logic              wrap;

    assign n_legal = (N == 4'd2) || (N == 4'd3) || (N == 4'd4);
    // Also catches turn already beyond N after N was lowered mid-game.
    assign wrap    = ({2'b00, turn} + 4'd1) >= N;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        turn_next      = turn;
        case (state)
            IDLE: begin
                if (start && n_legal) begin
                    if (steps != '0) begin
                        state_next     = STEP;
                        remaining_next = steps - 1'b1;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            STEP: begin
                if (remaining == '0) begin
                    state_next = FIN;
                end else begin
                    remaining_next = remaining - 1'b1;
`ifdef MOVE_ISSUER_GAP_EN
                    state_next     = GAP;
`else
                    state_next     = STEP;
`endif
                end
            end
            GAP: state_next = STEP;
            FIN: begin
                state_next = IDLE;
                turn_next  = wrap ? 2'd0 : turn + 2'd1;
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without extra latency.
        p_da_next = (state_next == STEP) ? (4'b0001 << turn_next) : 4'b0000;
        busy_next = (state_next == STEP) || (state_next == GAP);
        done_next = (state_next == FIN);
    end

    always_ff @(posedge B or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            turn      <= 2'd0;
            p_da      <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            turn      <= turn_next;
            p_da      <= p_da_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_move_issuer.sv
// Randomised bench for move_issuer against a per-move timeline model; also covers MOVE_ISSUER_GAP_EN builds.
module tb_move_issuer;

    localparam int STEP_W = 3;

    logic              B;
    logic              rst;
    logic [3:0]        N;
    logic              start;
    logic [STEP_W-1:0] steps;
    logic [3:0]        p_da;
    logic [1:0]        turn;
    logic              busy;
    logic              done;

    int total  = 0;
    int passed = 0;

    // Model: a move is a timeline indexed by k cycles since acceptance.
    bit moving = 0;
    int mk     = 0;
    int ms     = 0;
    int mturn  = 0;

    move_issuer #(.STEP_W(STEP_W)) dut (
        .B     (B),
        .rst   (rst),
        .N     (N),
        .start (start),
        .steps (steps),
        .p_da  (p_da),
        .turn  (turn),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        B = 1'b0;
        forever #5 B = ~B;
    end

    function automatic int mlen(input int s);
`ifdef MOVE_ISSUER_GAP_EN
        return (s == 0) ? 0 : 2 * s - 1;
`else
        return s;
`endif
    endfunction

    function automatic bit mstrobe(input int k);
`ifdef MOVE_ISSUER_GAP_EN
        return (k % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        moving = 0;
        mk     = 0;
        ms     = 0;
        mturn  = 0;
    endtask

    task automatic model_edge();
        if (!moving) begin
            if (start && int'(N) >= 2 && int'(N) <= 4) begin
                moving = 1;
                ms     = int'(steps);
                mk     = 0;
                $display("move: t=%0t player=%0d steps=%0d N=%0d", $time, mturn, ms, N);
            end
        end else if (mk == mlen(ms)) begin
            moving = 0;
            mturn  = (mturn + 1 >= int'(N)) ? 0 : mturn + 1;
        end else begin
            mk++;
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_pda;
        logic       e_busy;
        logic       e_done;
        e_busy = moving && (mk < mlen(ms));
        e_done = moving && (mk == mlen(ms));
        e_pda  = (e_busy && mstrobe(mk)) ? (4'b0001 << mturn) : 4'b0000;
        chk("p_da", {28'd0, p_da}, {28'd0, e_pda});
        chk("turn", {30'd0, turn}, mturn);
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("done", {31'd0, done}, {31'd0, e_done});
    endtask

    always @(posedge B) begin
        if (!rst) begin
            model_edge();
            #1;
            compare_all();
        end
    end

    // Drive inputs on the falling edge; return just after the next rising edge has been checked.
    task automatic cyc(input bit st, input int sp, input int n);
        @(negedge B);
        start = st;
        steps = sp[STEP_W-1:0];
        N     = n[3:0];
        @(posedge B);
        #2;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        chk({tag, "_pda"},  {28'd0, p_da}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_turn"}, {30'd0, turn}, 32'd0);
        @(negedge B);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        steps = '0;
        N     = 4'd2;
        model_reset();
        @(posedge B);
        #1;
        chk("rst_pda",  {28'd0, p_da}, 32'd0);
        chk("rst_turn", {30'd0, turn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge B);
        rst = 1'b0;

        // Two-player game: three steps for player 0, then one for player 1.
`ifdef MOVE_ISSUER_GAP_EN
        cyc(1, 3, 2); chk("g_s1", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("g_s2", {28'd0, p_da}, 32'h0);
        cyc(0, 0, 2); chk("g_s3", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("g_s4", {28'd0, p_da}, 32'h0);
        cyc(0, 0, 2); chk("g_s5", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("g_done", {31'd0, done}, 32'd1);
`else
        cyc(1, 3, 2); chk("s1", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("s2", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("s3", {28'd0, p_da}, 32'h1);
        cyc(0, 0, 2); chk("done3", {31'd0, done}, 32'd1);
`endif
        cyc(0, 0, 2); chk("turn_to1", {30'd0, turn}, 32'd1);
        cyc(1, 1, 2); chk("p1_strobe", {28'd0, p_da}, 32'h2);
        cyc(0, 0, 2); chk("done1", {31'd0, done}, 32'd1);
        cyc(0, 0, 2); chk("turn_wrap", {30'd0, turn}, 32'd0);

        // Miss: zero steps goes straight to done.
        cyc(1, 0, 3); chk("miss_done", {31'd0, done}, 32'd1);
        chk("miss_pda", {28'd0, p_da}, 32'd0);
        cyc(0, 0, 3); chk("miss_turn", {30'd0, turn}, 32'd1);

        // Illegal player counts are ignored.
        cyc(1, 2, 5); chk("n5_busy", {31'd0, busy}, 32'd0);
        cyc(1, 2, 1); chk("n1_busy", {31'd0, busy}, 32'd0);
        chk("nbad_turn", {30'd0, turn}, 32'd1);

        // Four players, two steps each, starting from player 1.
        for (int m = 0; m < 4; m++) begin
            cyc(1, 2, 4);
            chk("n4_first", {28'd0, p_da}, 32'(1 << ((1 + m) % 4)));
            repeat (5) cyc(0, 0, 4);
        end
        chk("n4_turn", {30'd0, turn}, 32'd1);

        // Start held high across back-to-back moves.
        repeat (24) cyc(1, 5, 4);
        repeat (12) cyc(0, 0, 4);

        // Reset in the middle of a move.
        cyc(1, 4, 2);
        cyc(0, 0, 2);
        pulse_reset("midrst");
        repeat (6) cyc(0, 0, 2);
        chk("post_rst_pda", {28'd0, p_da}, 32'd0);

        // Random traffic, including N changes mid-move and occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            int n_r;
            n_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(2, 4);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7), n_r);
            if ($urandom_range(0, 299) == 0) pulse_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
